// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multi-cycle MIPS control FSM (Moore) for lw, sw, R-type, beq, addi and j.
//   clk, reset_n (async, active-low)      clock and reset of the state register
//   op, funct                             instruction opcode / R-type function field
//   zero                                  ALU zero flag, used only for the branch decision
//   alucontrol, alusrca, alusrcb          ALU operation and operand selects
//   lord, irwrite, memwrite               memory address select and write enables
//   regwrite, regdst, memtoreg            register-file write controls
//   pcsrc, pcen                           PC source select and load enable
//   illegal_op                            DECODE-cycle pulse on an unsupported opcode
//   state                                 current state encoding for debug
module mips_mc_controller (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] alucontrol,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       lord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       illegal_op,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   state_t state_q, state_d;
   logic   irwrite_m, memwrite_m, regwrite_m, illegal_m, pcwrite, branch;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= FETCH;
      else          state_q <= state_d;

   always_comb begin
      state_d    = FETCH;
      alucontrol = 3'b010;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      lord       = 1'b0;
      irwrite_m  = 1'b0;
      memwrite_m = 1'b0;
      regwrite_m = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      pcsrc      = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      illegal_m  = 1'b0;
      case (state_q)
         FETCH: begin
            irwrite_m = 1'b1;
            pcwrite   = 1'b1;
            alusrcb   = 2'b01;
            state_d   = DECODE;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               6'b100011, 6'b101011: state_d = MEMADR;
               6'b000000:            state_d = EXECUTE;
               6'b000100:            state_d = BRANCH;
               6'b001000:            state_d = ADDIEXEC;
               6'b000010:            state_d = JUMP;
               default:              illegal_m = 1'b1;
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == 6'b101011) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            lord    = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            regwrite_m = 1'b1;
            memtoreg   = 1'b1;
         end
         MEMWR: begin
            lord       = 1'b1;
            memwrite_m = 1'b1;
         end
         EXECUTE: begin
            alusrca    = 1'b1;
            alucontrol = (funct == 6'b100010) ? 3'b110 :
                         (funct == 6'b100100) ? 3'b000 :
                         (funct == 6'b100101) ? 3'b001 :
                         (funct == 6'b101010) ? 3'b111 : 3'b010;
            state_d    = ALUWB;
         end
         ALUWB: begin
            regwrite_m = 1'b1;
            regdst     = 1'b1;
         end
         BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            branch     = 1'b1;
         end
         ADDIEXEC: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = ADDIWB;
         end
         ADDIWB: regwrite_m = 1'b1;
         JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // Write enables are gated by reset_n so an asynchronous reset kills them in the same cycle.
   assign irwrite    = irwrite_m & reset_n;
   assign memwrite   = memwrite_m & reset_n;
   assign regwrite   = regwrite_m & reset_n;
   assign illegal_op = illegal_m & reset_n;
   assign pcen       = (pcwrite | (branch & zero)) & reset_n;
   assign state      = state_q;
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: table-driven and randomized checking of mips_mc_controller against an instruction-level model.
module tb_mips_mc_controller;
   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic [2:0] alucontrol;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       lord, irwrite, memwrite, regwrite, regdst, memtoreg;
   logic [1:0] pcsrc;
   logic       pcen, illegal_op;
   logic [3:0] state;
   logic [19:0] act;
   int checks = 0;
   int failures = 0;

   mips_mc_controller dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
      .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb),
      .lord(lord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
      .regdst(regdst), .memtoreg(memtoreg), .pcsrc(pcsrc), .pcen(pcen),
      .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   assign act = {state, alucontrol, alusrca, alusrcb, lord, irwrite, memwrite,
                 regwrite, regdst, memtoreg, pcsrc, pcen, illegal_op};

   // Bits cleared while reset is held: irwrite, memwrite, regwrite, pcen, illegal_op.
   localparam logic [19:0] RST_MASK = 20'h001C3;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] funct;
      int         zmode;
      int         lat;
      logic [23:0] seq;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, a, e, $time);
      end
   endtask

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'h20: return 3'b010;
         6'h22: return 3'b110;
         6'h24: return 3'b000;
         6'h25: return 3'b001;
         6'h2a: return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   // Instruction latency from FETCH back to FETCH.
   function automatic int plen(input logic [5:0] o);
      case (o)
         6'h23: return 5;
         6'h2b, 6'h00, 6'h08: return 4;
         6'h04, 6'h02: return 3;
         default: return 2;
      endcase
   endfunction

   // Step i of an instruction: FETCH, DECODE, then the class-specific tail.
   function automatic int pst(input logic [5:0] o, input int i);
      if (i == 0) return 0;
      if (i == 1) return 1;
      case (o)
         6'h23: return i + 0;
         6'h2b: return (i == 2) ? 2 : 5;
         6'h00: return (i == 2) ? 6 : 7;
         6'h08: return (i == 2) ? 9 : 10;
         6'h04: return 8;
         6'h02: return 11;
         default: return 0;
      endcase
   endfunction

   function automatic logic [19:0] exp_out(input int s, input logic [5:0] o, input logic [5:0] f, input logic z);
      logic [2:0] alu = 3'b010;
      logic sa = 0, lo = 0, irw = 0, mw = 0, rw = 0, rd = 0, mtr = 0, pe = 0, ill = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      case (s)
         0: begin irw = 1; pe = 1; sb = 2'b01; end
         1: begin sb = 2'b11; ill = (plen(o) == 2); end
         2, 9: begin sa = 1; sb = 2'b10; end
         3: lo = 1;
         4: begin rw = 1; mtr = 1; end
         5: begin lo = 1; mw = 1; end
         6: begin sa = 1; alu = alu_of(f); end
         7: begin rw = 1; rd = 1; end
         8: begin sa = 1; alu = 3'b110; ps = 2'b01; pe = z; end
         10: rw = 1;
         11: begin ps = 2'b10; pe = 1; end
         default: ;
      endcase
      return {4'(s), alu, sa, sb, lo, irw, mw, rw, rd, mtr, ps, pe, ill};
   endfunction

   // One cycle: drive inputs at negedge (garbage op/funct outside the sampling states), check #1 later.
   task automatic step(input logic [5:0] o, input logic [5:0] f, input int s, input int zm, input string nm);
      logic z;
      logic smp;
      @(negedge clk);
      smp = (s == 1) || (s == 2) || (s == 6);
      op = smp ? o : 6'($urandom);
      funct = smp ? f : 6'($urandom);
      z = (zm == 2) ? 1'($urandom) : (zm == 1);
      zero = z;
      #1;
      chk(nm, {12'd0, act}, {12'd0, exp_out(s, o, f, z)});
   endtask

   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zm, input string nm,
                            output logic [23:0] obs, output int lat);
      int n = plen(o);
      obs = '0;
      for (int i = 0; i < n; i++) begin
         step(o, f, pst(o, i), zm, nm);
         obs[4*i +: 4] = state;
      end
      @(posedge clk);
      #1;
      lat = (state == 4'd0) ? n : -1;
   endtask

   vec_t vt[$];
   logic [23:0] obs;
   int lat;

   initial begin
      vt.push_back('{"lw",       6'h23, 6'h00, 0, 5, 24'h043210});
      vt.push_back('{"sw",       6'h2b, 6'h00, 0, 4, 24'h005210});
      vt.push_back('{"r_slt",    6'h00, 6'h2a, 0, 4, 24'h007610});
      vt.push_back('{"r_add",    6'h00, 6'h20, 1, 4, 24'h007610});
      vt.push_back('{"r_sub",    6'h00, 6'h22, 0, 4, 24'h007610});
      vt.push_back('{"r_and",    6'h00, 6'h24, 0, 4, 24'h007610});
      vt.push_back('{"r_or",     6'h00, 6'h25, 0, 4, 24'h007610});
      vt.push_back('{"r_badfn",  6'h00, 6'h3f, 0, 4, 24'h007610});
      vt.push_back('{"beq_z1",   6'h04, 6'h00, 1, 3, 24'h000810});
      vt.push_back('{"beq_z0",   6'h04, 6'h00, 0, 3, 24'h000810});
      vt.push_back('{"addi",     6'h08, 6'h00, 0, 4, 24'h00a910});
      vt.push_back('{"j",        6'h02, 6'h00, 0, 3, 24'h000b10});
      vt.push_back('{"ill_3f",   6'h3f, 6'h00, 0, 2, 24'h000010});
      vt.push_back('{"ill_01",   6'h01, 6'h00, 1, 2, 24'h000010});

      // Asynchronous reset: outputs forced before any clock edge, held across edges.
      #1 reset_n = 1'b0;
      op = 6'h23;
      #1 chk("rst_async", {12'd0, act}, {12'd0, exp_out(0, 0, 0, 0) & ~RST_MASK});
      repeat (2) @(posedge clk);
      op = 6'h04; zero = 1'b1;
      #1 chk("rst_held", {12'd0, act}, {12'd0, exp_out(0, 0, 0, 0) & ~RST_MASK});
      @(posedge clk);
      #1 reset_n = 1'b1;

      foreach (vt[k]) begin
         run_instr(vt[k].op, vt[k].funct, vt[k].zmode, vt[k].name, obs, lat);
         chk({vt[k].name, "_seq"}, {8'd0, obs}, {8'd0, vt[k].seq});
         chk({vt[k].name, "_lat"}, lat, vt[k].lat);
      end

      // Reset during MEMWR aborts the store before the next clock edge, then FETCH restarts.
      step(6'h2b, 6'h00, 0, 0, "mid_fetch");
      step(6'h2b, 6'h00, 1, 0, "mid_decode");
      step(6'h2b, 6'h00, 2, 0, "mid_memadr");
      step(6'h2b, 6'h00, 5, 0, "mid_memwr");
      #1 reset_n = 1'b0;
      #1 chk("mid_rst", {12'd0, act}, {12'd0, exp_out(0, 0, 0, 0) & ~RST_MASK});
      @(posedge clk);
      #1 reset_n = 1'b1;
      run_instr(6'h23, 6'h00, 2, "after_rst", obs, lat);
      chk("after_rst_seq", {8'd0, obs}, {8'd0, 24'h043210});
      chk("after_rst_lat", lat, 5);

      // Random instruction stream with random zero every cycle.
      for (int r = 0; r < 80; r++) begin
         logic [5:0] o;
         logic [5:0] f;
         int pick = $urandom_range(0, 9);
         o = (pick == 0) ? 6'h23 : (pick == 1) ? 6'h2b : (pick == 2) ? 6'h00 :
             (pick == 3) ? 6'h04 : (pick == 4) ? 6'h08 : (pick == 5) ? 6'h02 : 6'($urandom);
         f = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'h20 + 6'($urandom_range(0, 10));
         run_instr(o, f, 2, "rand", obs, lat);
         chk("rand_lat", lat, plen(o));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
